// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch input-side control path.
// Contents: FSM state encoding, push-button index map and the wrap limits
// of the MM:SS digits (units digits wrap after 9, tens digits after 5).
package stopwatch_pkg;

  // Code 2'd3 is never produced; the FSM falls back to STOP if it appears.
  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    SET  = 2'd2
  } state_t;

  localparam int KEY_MODE  = 0;
  localparam int KEY_SEL   = 1;
  localparam int KEY_INC   = 2;
  localparam int KEY_START = 3;

  localparam logic [3:0] DIGIT_MAX_EVEN = 4'd9;
  localparam logic [3:0] DIGIT_MAX_ODD  = 4'd5;

endpackage

// File: rtl/key_debounce.sv
// Single push-button conditioner: two-flop synchronizer, sample-tick based
// debounce counter and a one-cycle rising-edge pulse.
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   i_smpStb    one-cycle debounce sample tick
//   i_keyRaw    raw, asynchronous button level (active-high)
//   o_keyPulse  one-cycle pulse the cycle after the debounced level rises
module key_debounce #(
  parameter int DEB_CNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_smpStb,
  input  logic i_keyRaw,
  output logic o_keyPulse
);

  // Counter value on which the DEB_CNT-th consecutive differing tick lands.
  localparam logic [3:0] CNT_LAST = 4'(DEB_CNT - 1);

  logic [1:0] r_sync;
  logic       r_stable;
  logic       r_stableDly;
  logic [3:0] r_cnt;
  logic       r_pulse;
  logic       w_synced;

  assign w_synced   = r_sync[1];
  assign o_keyPulse = r_pulse;

  // Bring the raw level into the clock domain before it is looked at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_keyRaw};
    end
  end

  // The debounced level only moves after DEB_CNT sample ticks in a row
  // disagree with it; any agreeing tick restarts the count, so a bounce
  // never accumulates towards a change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= 1'b0;
      r_cnt    <= 4'd0;
    end else if (i_smpStb) begin
      if (w_synced != r_stable) begin
        if (r_cnt == CNT_LAST) begin
          r_stable <= w_synced;
          r_cnt    <= 4'd0;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end else begin
        r_cnt <= 4'd0;
      end
    end
  end

  // Press pulse is registered from the delayed debounced level, so it
  // appears the cycle after the level rises; releases produce nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stableDly <= 1'b0;
      r_pulse     <= 1'b0;
    end else begin
      r_stableDly <= r_stable;
      r_pulse     <= r_stable & ~r_stableDly;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Stopwatch input controller: debounces the four buttons, runs the
// STOP/RUN/SET state machine and edits MM:SS digit by digit in SET,
// finishing with a one-cycle load strobe into the counter chain.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   smp_stb      debounce sample tick
//   blink_stb    blink phase toggle tick
//   keys_raw     raw buttons [0] mode [1] select [2] increment [3] start/stop
//   cnt_data_i   current counter digits, digit0 at [3:0]
//   run          counting enable (high exactly while in RUN)
//   load         one-cycle strobe, counters take load_data
//   load_data    edited digits, held between loads
//   dig_blank    display blank mask, blinks the digit being edited
//   key_pulse    debounced press pulses
//   state_o      current FSM state
module time_set_ctrl
  import stopwatch_pkg::*;
#(
  parameter int         DEB_CNT  = 4,
  parameter logic [3:0] MAX_EVEN = DIGIT_MAX_EVEN,
  parameter logic [3:0] MAX_ODD  = DIGIT_MAX_ODD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        smp_stb,
  input  logic        blink_stb,
  input  logic [3:0]  keys_raw,
  input  logic [15:0] cnt_data_i,
  output logic        run,
  output logic        load,
  output logic [15:0] load_data,
  output logic [3:0]  dig_blank,
  output logic [3:0]  key_pulse,
  output logic [1:0]  state_o
);

  state_t      r_state;
  state_t      w_nextState;
  logic [15:0] r_edit;
  logic [1:0]  r_selIdx;
  logic        r_blink;
  logic        r_run;
  logic        r_load;
  logic [15:0] r_loadData;
  logic [3:0]  w_keyPulse;
  logic        w_mode;
  logic        w_start;
  logic        w_sel;
  logic        w_inc;
  logic [3:0]  w_curDigit;
  logic [3:0]  w_maxDigit;
  logic [3:0]  w_incDigit;

  for (genvar k = 0; k < 4; k++) begin : g_keys
    key_debounce #(
      .DEB_CNT(DEB_CNT)
    ) u_keyDebounce (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_smpStb  (smp_stb),
      .i_keyRaw  (keys_raw[k]),
      .o_keyPulse(w_keyPulse[k])
    );
  end

  // Only one key acts per cycle: mode > start > select > increment.
  assign w_mode  = w_keyPulse[KEY_MODE];
  assign w_start = w_keyPulse[KEY_START] & ~w_mode;
  assign w_sel   = w_keyPulse[KEY_SEL] & ~w_mode & ~w_keyPulse[KEY_START];
  assign w_inc   = w_keyPulse[KEY_INC] & ~w_mode & ~w_keyPulse[KEY_START]
                 & ~w_keyPulse[KEY_SEL];

  // Odd digit positions are tens and wrap earlier; a digit loaded above its
  // limit also returns to zero on the next increment.
  assign w_curDigit = r_edit[{r_selIdx, 2'b00} +: 4];
  assign w_maxDigit = r_selIdx[0] ? MAX_ODD : MAX_EVEN;
  assign w_incDigit = (w_curDigit >= w_maxDigit) ? 4'd0 : w_curDigit + 4'd1;

  assign key_pulse = w_keyPulse;
  assign run       = r_run;
  assign load      = r_load;
  assign load_data = r_loadData;
  assign state_o   = r_state;
  assign dig_blank = (r_state == SET && r_blink) ? (4'b0001 << r_selIdx) : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= STOP;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      STOP: begin
        if (w_mode) begin
          w_nextState = SET;
        end else if (w_start) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (w_start) begin
          w_nextState = STOP;
        end
      end
      SET: begin
        if (w_mode) begin
          w_nextState = STOP;
        end
      end
      default: w_nextState = STOP;
    endcase
  end

  // Edit register, digit cursor, blink phase and load handshake. run is
  // derived from the next state so it changes on the same edge as state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edit     <= 16'h0000;
      r_selIdx   <= 2'd3;
      r_blink    <= 1'b0;
      r_run      <= 1'b0;
      r_load     <= 1'b0;
      r_loadData <= 16'h0000;
    end else begin
      r_load <= 1'b0;
      r_run  <= (w_nextState == RUN);
      case (r_state)
        STOP: begin
          if (w_mode) begin
            r_edit   <= cnt_data_i;
            r_selIdx <= 2'd3;
            r_blink  <= 1'b0;
          end
        end
        SET: begin
          if (blink_stb) begin
            r_blink <= ~r_blink;
          end
          if (w_mode) begin
            r_load     <= 1'b1;
            r_loadData <= r_edit;
          end else if (w_sel) begin
            r_selIdx <= r_selIdx - 2'd1;
          end else if (w_inc) begin
            r_edit[{r_selIdx, 2'b00} +: 4] <= w_incDigit;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: every press pushes the expected
// key_pulse pattern, every edit exit pushes the expected load_data, and a
// negedge monitor pops and compares whenever the DUT emits a pulse or load.
module tb_time_set_ctrl;

  localparam int DEB_CNT = 4;
  localparam int HOLD    = DEB_CNT + 3;

  logic        clk;
  logic        rst_n;
  logic        smp_stb;
  logic        blink_stb;
  logic [3:0]  keys_raw;
  logic [15:0] cnt_data_i;
  logic        run;
  logic        load;
  logic [15:0] load_data;
  logic [3:0]  dig_blank;
  logic [3:0]  key_pulse;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;
  int tickCount = 0;

  logic [3:0]  expPulseQ[$];
  logic [15:0] expLoadQ[$];

  time_set_ctrl #(.DEB_CNT(DEB_CNT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .smp_stb   (smp_stb),
    .blink_stb (blink_stb),
    .keys_raw  (keys_raw),
    .cnt_data_i(cnt_data_i),
    .run       (run),
    .load      (load),
    .load_data (load_data),
    .dig_blank (dig_blank),
    .key_pulse (key_pulse),
    .state_o   (state_o)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sample tick every fourth clock, driven on the falling edge.
  initial begin
    smp_stb = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      smp_stb = 1'b1;
      @(negedge clk);
      smp_stb = 1'b0;
      tickCount++;
    end
  end

  // Global time limit so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: any pulse or load must match the head of its queue.
  always @(negedge clk) begin
    if (key_pulse != 4'b0000) begin
      if (expPulseQ.size() == 0) begin
        checkOutput("pulseExtra", 16'(key_pulse), 16'h0000);
      end else begin
        checkOutput("keyPulse", 16'(key_pulse), 16'(expPulseQ.pop_front()));
      end
    end
    if (load) begin
      if (expLoadQ.size() == 0) begin
        checkOutput("loadExtra", 16'(load), 16'h0000);
      end else begin
        checkOutput("loadData", load_data, expLoadQ.pop_front());
      end
    end
  end

  task automatic waitTicks(input int n);
    int target;
    target = tickCount + n;
    while (tickCount < target) @(negedge clk);
  endtask

  // Press a key combination (optionally with a 1-0 bounce first), hold it
  // long enough to debounce, release and let the release settle.
  task automatic applyStimulus(input logic [3:0] keys, input bit bounce);
    expPulseQ.push_back(keys);
    if (bounce) begin
      keys_raw = keys;
      waitTicks(1);
      keys_raw = 4'b0000;
      waitTicks(1);
    end
    keys_raw = keys;
    waitTicks(HOLD);
    keys_raw = 4'b0000;
    waitTicks(HOLD);
    @(negedge clk);
  endtask

  task automatic pulseBlink();
    @(negedge clk);
    blink_stb = 1'b1;
    @(negedge clk);
    blink_stb = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    blink_stb  = 1'b0;
    keys_raw   = 4'b0000;
    cnt_data_i = 16'h0000;
    repeat (3) @(negedge clk);
    checkOutput("rstState", 16'(state_o), 16'h0000);
    checkOutput("rstRun", 16'(run), 16'h0000);
    checkOutput("rstLoad", 16'(load), 16'h0000);
    checkOutput("rstLoadData", load_data, 16'h0000);
    checkOutput("rstBlank", 16'(dig_blank), 16'h0000);
    checkOutput("rstPulse", 16'(key_pulse), 16'h0000);
    rst_n = 1'b1;

    // Idle: no pulse may appear (monitor flags any).
    waitTicks(100);
    checkOutput("idleState", 16'(state_o), 16'h0000);

    // Start with bounce -> RUN, again -> STOP.
    applyStimulus(4'b1000, 1'b1);
    checkOutput("runState", 16'(state_o), 16'h0001);
    checkOutput("runOn", 16'(run), 16'h0001);
    applyStimulus(4'b1000, 1'b0);
    checkOutput("stopState", 16'(state_o), 16'h0000);
    checkOutput("runOff", 16'(run), 16'h0000);

    // Edit 59:23, bump tens of minutes 5->0, load 09:23.
    cnt_data_i = 16'h5923;
    applyStimulus(4'b0001, 1'b0);
    checkOutput("setState", 16'(state_o), 16'h0002);
    checkOutput("blankPhase0", 16'(dig_blank), 16'h0000);
    pulseBlink();
    checkOutput("blankDig3", 16'(dig_blank), 16'h0008);
    applyStimulus(4'b0100, 1'b0);
    expLoadQ.push_back(16'h0923);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("afterLoadState", 16'(state_o), 16'h0000);
    checkOutput("heldLoadData", load_data, 16'h0923);
    checkOutput("blankOutsideSet", 16'(dig_blank), 16'h0000);

    // Cursor walk and wrap on units / out-of-range tens.
    cnt_data_i = 16'h0079;
    applyStimulus(4'b0001, 1'b0);
    pulseBlink();
    checkOutput("sel3", 16'(dig_blank), 16'h0008);
    applyStimulus(4'b1000, 1'b0);
    checkOutput("startIgnoredInSet", 16'(state_o), 16'h0002);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("sel2", 16'(dig_blank), 16'h0004);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("sel1", 16'(dig_blank), 16'h0002);
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("sel0", 16'(dig_blank), 16'h0001);
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("selWrap", 16'(dig_blank), 16'h0008);
    applyStimulus(4'b0100, 1'b0);
    expLoadQ.push_back(16'h1000);
    applyStimulus(4'b0001, 1'b0);

    // Mode and start together in STOP: mode wins.
    cnt_data_i = 16'h1234;
    applyStimulus(4'b1001, 1'b0);
    checkOutput("prioState", 16'(state_o), 16'h0002);
    checkOutput("prioRun", 16'(run), 16'h0000);
    expLoadQ.push_back(16'h1234);
    applyStimulus(4'b0001, 1'b0);

    // Mode is ignored in RUN (monitor flags any load).
    applyStimulus(4'b1000, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("modeInRun", 16'(state_o), 16'h0001);
    applyStimulus(4'b1000, 1'b0);
    checkOutput("backToStop", 16'(state_o), 16'h0000);

    // Reset mid-edit discards the edit.
    cnt_data_i = 16'h4321;
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    pulseBlink();
    checkOutput("preRstBlank", 16'(dig_blank), 16'h0008);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstState", 16'(state_o), 16'h0000);
    checkOutput("midRstBlank", 16'(dig_blank), 16'h0000);
    checkOutput("midRstLoad", 16'(load), 16'h0000);
    checkOutput("midRstLoadData", load_data, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_data_i = 16'h0042;
    applyStimulus(4'b0001, 1'b0);
    expLoadQ.push_back(16'h0042);
    applyStimulus(4'b0001, 1'b0);

    waitTicks(4);
    checkOutput("pulseQEmpty", 16'(expPulseQ.size()), 16'h0000);
    checkOutput("loadQEmpty", 16'(expLoadQ.size()), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
